// File: rtl/control_ajuste.sv
// control_ajuste: edit-mode controller that sequences a 3-field settable value (e.g. hh:mm:ss).
// Define CTRL_TIMEOUT_EN to build the inactivity auto-exit (parameter TMO_CYC).
module control_ajuste #(
  parameter int W    = 6,
  parameter int MAX0 = 23,
  parameter int MAX1 = 59,
  parameter int MAX2 = 59
`ifdef CTRL_TIMEOUT_EN
  ,
  parameter int TMO_CYC = 1000
`endif
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         aumentar,
  input  logic         disminuir,
  input  logic         siguiente,
  output logic         editando,
  output logic [1:0]   campo,
  output logic [W-1:0] valor0,
  output logic [W-1:0] valor1,
  output logic [W-1:0] valor2,
  output logic         cambio
);

  // The encoding doubles as the campo output: field index while editing, 3 when idle.
  typedef enum logic [1:0] {
    EDIT0 = 2'd0,
    EDIT1 = 2'd1,
    EDIT2 = 2'd2,
    IDLE  = 2'd3
  } state_t;

  localparam logic [W-1:0] MAX0_V = W'(MAX0);
  localparam logic [W-1:0] MAX1_V = W'(MAX1);
  localparam logic [W-1:0] MAX2_V = W'(MAX2);

  state_t         state_q, state_d;
  logic           editando_q, editando_d;
  logic [W-1:0]   valor0_q, valor0_d;
  logic [W-1:0]   valor1_q, valor1_d;
  logic [W-1:0]   valor2_q, valor2_d;
  logic           cambio_q, cambio_d;
  logic           evInc, evDec, evSig, stepEn, tmoHit;

  function automatic logic [W-1:0] stepField(input logic [W-1:0] v,
                                             input logic [W-1:0] maxV,
                                             input logic         up);
    if (up) return (v == maxV) ? '0 : v + W'(1);
    else    return (v == '0) ? maxV : v - W'(1);
  endfunction

  assign evInc  = ~aumentar;
  assign evDec  = ~disminuir;
  assign evSig  = ~siguiente;
  // A step is applied only in edit mode, without a concurrent sig, and with exactly one of inc/dec.
  assign stepEn = (state_q != IDLE) && !evSig && (evInc ^ evDec);

`ifdef CTRL_TIMEOUT_EN
  localparam int TW = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;

  logic [TW-1:0] tmo_q, tmo_d;

  always_comb begin
    tmo_d  = tmo_q;
    tmoHit = 1'b0;
    if (state_q == IDLE || evSig || stepEn) begin
      tmo_d = '0;
    end else if (tmo_q == TW'(TMO_CYC - 1)) begin
      tmo_d  = '0;
      tmoHit = 1'b1;
    end else begin
      tmo_d = tmo_q + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end
`else
  assign tmoHit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    valor0_d = valor0_q;
    valor1_d = valor1_q;
    valor2_d = valor2_q;
    cambio_d = 1'b0;
    if (evSig) begin
      unique case (state_q)
        IDLE:    state_d = EDIT0;
        EDIT0:   state_d = EDIT1;
        EDIT1:   state_d = EDIT2;
        default: state_d = IDLE;
      endcase
    end else if (stepEn) begin
      cambio_d = 1'b1;
      unique case (state_q)
        EDIT0:   valor0_d = stepField(valor0_q, MAX0_V, evInc);
        EDIT1:   valor1_d = stepField(valor1_q, MAX1_V, evInc);
        EDIT2:   valor2_d = stepField(valor2_q, MAX2_V, evInc);
        default: cambio_d = 1'b0;
      endcase
    end else if (tmoHit) begin
      state_d = IDLE;
    end
    editando_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      editando_q <= 1'b0;
      valor0_q   <= '0;
      valor1_q   <= '0;
      valor2_q   <= '0;
      cambio_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      editando_q <= editando_d;
      valor0_q   <= valor0_d;
      valor1_q   <= valor1_d;
      valor2_q   <= valor2_d;
      cambio_q   <= cambio_d;
    end
  end

  assign editando = editando_q;
  assign campo    = state_q;
  assign valor0   = valor0_q;
  assign valor1   = valor1_q;
  assign valor2   = valor2_q;
  assign cambio   = cambio_q;

endmodule
